parking_token_issuer: RTL
=========================

Name: parking_token_issuer

Overview:
- System-side counterpart of the parking entry controller.
- On a driver request, issues a pseudo-random access token and shows it on the display.
- Waits for the driver to confirm a keyed-in token, then grants entry (opens the gate, takes one space) or denies it.
- Tracks free spaces; cars leaving through the exit sensor return spaces.

Parameters:
- TOKEN_W, 3, width of system_token and user_token.
- SPACES, 8, lot capacity; reset value of free_spaces.
- TIMEOUT, 32, cycles allowed in WAIT_CONFIRM before denial.
- MAX_TRIES, 3, wrong-token confirms allowed before denial.
- GATE_CYCLES, 16, cycles gate_open stays high after a grant.
- LFSR_SEED, 8'hA5, nonzero seed of the 8-bit token LFSR.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- request  in  1  driver present / request level.
- confirm  in  1  driver confirm key level.
- user_token  in  TOKEN_W  token keyed in by the driver.
- car_exit  in  1  one-cycle pulse from the exit sensor.
- system_token  out  TOKEN_W  issued token; 0 when token_valid=0.
- token_valid  out  1  display-enable for system_token.
- grant  out  1  one-cycle pulse on successful entry.
- gate_open  out  1  entry-gate drive.
- deny  out  1  held high while in DENY.
- lot_full  out  1  one-cycle pulse when a request is refused because free_spaces==0.
- free_spaces  out  $clog2(SPACES+1)  spaces remaining.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all outputs 0 except free_spaces=SPACES.
  - LFSR=LFSR_SEED; tries=0; timer=0.
  - request_d and confirm_d cleared.
- Edge detection:
  - request_d and confirm_d are registered copies of the inputs.
  - req_rise = request & ~request_d; conf_rise = confirm & ~confirm_d.
- LFSR:
  - 8-bit Galois, taps x^8+x^6+x^5+x^4+1.
  - Free-running every cycle out of reset; never all-zero.
- IDLE:
  - On req_rise with free_spaces>0: go to ISSUE.
  - On req_rise with free_spaces==0: lot_full=1 for one cycle, stay in IDLE.
- ISSUE (one cycle):
  - Latch token = LFSR[TOKEN_W-1:0].
  - Clear tries and timer; go to WAIT_CONFIRM.
  - token_valid and system_token take effect on the cycle after ISSUE.
- WAIT_CONFIRM, checked in priority order:
  1. request=0: go to IDLE, clear token_valid and system_token (abort).
  2. conf_rise with user_token==token: go to GRANT.
  3. conf_rise with a mismatch: tries+1. If the new tries==MAX_TRIES, go to DENY.
  4. timer==TIMEOUT-1: go to DENY. Otherwise timer+1.
  - A held confirm counts once (rising edge only).
- GRANT:
  - grant=1 for exactly one cycle.
  - free_spaces-1 on the same edge.
  - gate_open=1 for GATE_CYCLES cycles starting on the next cycle.
  - token_valid is cleared.
  - Then go to DONE.
- DONE: hold until request=0, then go to IDLE.
- DENY:
  - deny=1 and token_valid=0.
  - Hold until request=0, then go to IDLE.
- free_spaces update:
  - Increments on car_exit, saturating at SPACES.
  - Decrements only on grant.
  - Grant and car_exit in the same cycle: net unchanged.
- Latency: req_rise to token_valid=1 is 2 cycles. Matching conf_rise to grant is 1 cycle.
- Request dropped in any state other than IDLE: go to IDLE next cycle. Exception: gate_open completes its count even if request drops.

Decomposition:
- Package parking_pkg:
  - State encoding enum: IDLE, ISSUE, WAIT_CONFIRM, GRANT, DONE, DENY.
  - TOKEN_W default.
  - LFSR tap constant.
- Sub-module token_lfsr: 8-bit LFSR with seed parameter and enable.
- Space counter and gate timer stay inline.

Test Plan:
- Reset: hold reset=0 mid-WAIT_CONFIRM -> outputs 0, free_spaces=8, state IDLE.
- Happy path: request 0->1, read system_token (X), user_token=X, confirm pulse -> grant pulse 1 cycle after the confirm edge, free_spaces 8->7, gate_open high 16 cycles.
- Wrong tokens: 3 confirm pulses with user_token=X^3'b001 -> deny=1 after the 3rd; first two leave the state in WAIT_CONFIRM; confirm held 10 cycles counts as one try.
- Timeout: request high, no confirm for 32 cycles -> deny=1 at cycle 32; request=0 -> IDLE, deny=0.
- Full lot: 8 grants, then request -> lot_full pulse, token_valid stays 0; car_exit pulse -> free_spaces=1; next request issues a token.
- Simultaneous: car_exit in the grant cycle -> free_spaces unchanged. car_exit at free_spaces=8 -> stays 8. Request drop in WAIT_CONFIRM -> IDLE, token_valid=0 next cycle.

Source files
------------

// File: rtl/parking_token_issuer_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
//   Shared definitions for the parking token issuer: the controller state
//   encoding, the default token width and the feedback mask of the 8-bit
//   token LFSR.
// ---------------------------------------------------------------------------
package parking_pkg;

  // Default width of the issued and keyed-in tokens.
  localparam int TOKEN_W_DEFAULT = 3;

  // Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 in right-shift form:
  // one bit at position (exponent - 1) for each non-constant term.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CONFIRM,
    GRANT,
    DONE,
    DENY
  } state_t;

endpackage

// File: rtl/parking_token_issuer_if.sv
// ---------------------------------------------------------------------------
// parking_token_issuer_if
//   Bundles the driver-side inputs and the display/gate/status outputs of
//   the parking token issuer.
//   slave  : seen by the issuer (inputs request/confirm/user_token/car_exit,
//            drives the token display, grant, gate, deny, lot_full and
//            free_spaces).
//   master : seen by whatever drives the issuer (the entry controller or a
//            testbench).
// ---------------------------------------------------------------------------
interface parking_token_issuer_if #(
  parameter int TOKEN_W = parking_pkg::TOKEN_W_DEFAULT,
  parameter int SPACES  = 8
);

  localparam int FS_W = $clog2(SPACES + 1);

  logic               request;
  logic               confirm;
  logic [TOKEN_W-1:0] user_token;
  logic               car_exit;

  logic [TOKEN_W-1:0] system_token;
  logic               token_valid;
  logic               grant;
  logic               gate_open;
  logic               deny;
  logic               lot_full;
  logic [FS_W-1:0]    free_spaces;

  modport slave (
    input  request, confirm, user_token, car_exit,
    output system_token, token_valid, grant, gate_open, deny, lot_full,
           free_spaces
  );

  modport master (
    output request, confirm, user_token, car_exit,
    input  system_token, token_valid, grant, gate_open, deny, lot_full,
           free_spaces
  );

endinterface

// File: rtl/parking_token_issuer_token_lfsr.sv
// ---------------------------------------------------------------------------
// token_lfsr
//   8-bit Galois LFSR (x^8 + x^6 + x^5 + x^4 + 1) used as the pseudo-random
//   token source. Advances once per cycle while en_i is high.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, loads SEED
//   en_i    : step enable
//   token_o : low OUT_W bits of the current LFSR state
// ---------------------------------------------------------------------------
module token_lfsr
  import parking_pkg::*;
#(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         OUT_W = TOKEN_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [OUT_W-1:0] token_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Right-shifting Galois step: the bit falling out of position 0 folds back
  // into the tap positions. With a nonzero seed and this maximal-length
  // polynomial the state never reaches all-zero.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign token_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/parking_token_issuer.sv
// ---------------------------------------------------------------------------
// parking_token_issuer
//   System side of the parking entry: on a driver request it issues a
//   pseudo-random token, waits for the driver to key it back in, then either
//   grants entry (one grant pulse, one space taken, gate opened for
//   GATE_CYCLES cycles) or denies it (too many wrong tries or timeout).
//   Exit-sensor pulses give spaces back, saturating at SPACES.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of parking_token_issuer_if (request, confirm,
//           user_token, car_exit in; system_token, token_valid, grant,
//           gate_open, deny, lot_full, free_spaces out)
// ---------------------------------------------------------------------------
module parking_token_issuer
  import parking_pkg::*;
#(
  parameter int         TOKEN_W     = TOKEN_W_DEFAULT,
  parameter int         SPACES      = 8,
  parameter int         TIMEOUT     = 32,
  parameter int         MAX_TRIES   = 3,
  parameter int         GATE_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  parking_token_issuer_if.slave bus
);

  localparam int FS_W    = $clog2(SPACES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int GATE_W  = $clog2(GATE_CYCLES + 1);

  localparam logic [FS_W-1:0]    FS_MAX      = FS_W'(SPACES);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [TRIES_W-1:0] TRIES_LIMIT = TRIES_W'(MAX_TRIES);
  localparam logic [GATE_W-1:0]  GATE_LOAD   = GATE_W'(GATE_CYCLES);

  state_t             state_q, state_d;
  logic [TOKEN_W-1:0] token_q, token_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               lot_full_q, lot_full_d;
  logic               request_dly_q;
  logic               confirm_dly_q;
  logic [FS_W-1:0]    free_q;
  logic [GATE_W-1:0]  gate_cnt_q;

  logic [TOKEN_W-1:0] lfsr_token;
  logic               req_rise;
  logic               conf_rise;
  logic [TRIES_W-1:0] tries_inc;
  logic               granting;

  // Free-running token source; the token is sampled from it in ISSUE.
  token_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (TOKEN_W)
  ) u_token_lfsr (
    .clk_i   (clock),
    .rst_ni  (reset),
    .en_i    (1'b1),
    .token_o (lfsr_token)
  );

  // Rising edges of the driver levels, so a held key counts only once.
  assign req_rise  = bus.request & ~request_dly_q;
  assign conf_rise = bus.confirm & ~confirm_dly_q;
  assign tries_inc = tries_q + TRIES_W'(1);
  assign granting  = (state_q == GRANT);

  // Next-state logic. Dropping request outside IDLE always aborts back to
  // IDLE. In WAIT_CONFIRM the checks form a strict priority chain, so a
  // cycle that consumes a wrong confirm does not also advance the timer.
  always_comb begin
    state_d    = state_q;
    token_d    = token_q;
    tries_d    = tries_q;
    timer_d    = timer_q;
    lot_full_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rise) begin
          if (free_q != '0) begin
            state_d = ISSUE;
          end else begin
            lot_full_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        token_d = lfsr_token;
        tries_d = '0;
        timer_d = '0;
        state_d = bus.request ? WAIT_CONFIRM : IDLE;
      end
      WAIT_CONFIRM: begin
        if (!bus.request) begin
          state_d = IDLE;
        end else if (conf_rise && (bus.user_token == token_q)) begin
          state_d = GRANT;
        end else if (conf_rise) begin
          tries_d = tries_inc;
          if (tries_inc == TRIES_LIMIT) begin
            state_d = DENY;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = DENY;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      GRANT: begin
        state_d = bus.request ? DONE : IDLE;
      end
      DONE, DENY: begin
        if (!bus.request) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers plus the one-cycle-delayed driver levels used for
  // edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      token_q       <= '0;
      tries_q       <= '0;
      timer_q       <= '0;
      lot_full_q    <= 1'b0;
      request_dly_q <= 1'b0;
      confirm_dly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      token_q       <= token_d;
      tries_q       <= tries_d;
      timer_q       <= timer_d;
      lot_full_q    <= lot_full_d;
      request_dly_q <= bus.request;
      confirm_dly_q <= bus.confirm;
    end
  end

  // Space counter: a grant takes a space on the edge that ends the grant
  // cycle, an exit gives one back (never above SPACES); both together
  // cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      free_q <= FS_MAX;
    end else begin
      case ({granting, bus.car_exit})
        2'b10:   free_q <= free_q - FS_W'(1);
        2'b01:   free_q <= (free_q == FS_MAX) ? free_q : free_q + FS_W'(1);
        default: free_q <= free_q;
      endcase
    end
  end

  // Gate timer: loaded at the end of the grant cycle so the gate opens on
  // the following cycle, then counts down on its own regardless of what the
  // controller does next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gate_cnt_q <= '0;
    end else if (granting) begin
      gate_cnt_q <= GATE_LOAD;
    end else if (gate_cnt_q != '0) begin
      gate_cnt_q <= gate_cnt_q - GATE_W'(1);
    end
  end

  // The token is only shown while the driver is expected to key it in.
  assign bus.token_valid  = (state_q == WAIT_CONFIRM);
  assign bus.system_token = (state_q == WAIT_CONFIRM) ? token_q : '0;
  assign bus.grant        = granting;
  assign bus.deny         = (state_q == DENY);
  assign bus.gate_open    = (gate_cnt_q != '0);
  assign bus.lot_full     = lot_full_q;
  assign bus.free_spaces  = free_q;

endmodule
